// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared widths, FSM states and counter sizing for the serial subtractor.
package serial_subtractor_pkg;
  localparam int C_W_DEF = 8;
  localparam int B_W_DEF = 4;
  localparam int A_W_DEF = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
  localparam int CNT_W = cnt_w(C_W_DEF);
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done request and result bundle of the serial subtractor.
interface serial_subtractor_if import serial_subtractor_pkg::*; #(
  parameter int C_W = C_W_DEF,
  parameter int B_W = B_W_DEF,
  parameter int A_W = A_W_DEF
);
  logic start;
  logic [C_W-1:0] c;
  logic [B_W-1:0] b;
  logic busy;
  logic done;
  logic [C_W-1:0] diff;
  logic [A_W-1:0] a;
  logic borrow;
  logic ovf;
  modport master (output start, c, b, input busy, done, diff, a, borrow, ovf);
  modport slave (input start, c, b, output busy, done, diff, a, borrow, ovf);
endinterface

// File: rtl/serial_subtractor_fs_cell.sv
// fs_cell: one-bit combinational full subtractor.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial c - b with borrow and narrow-result overflow flags.
module serial_subtractor import serial_subtractor_pkg::*; #(
  parameter int C_W = C_W_DEF,
  parameter int B_W = B_W_DEF,
  parameter int A_W = A_W_DEF
) (
  input logic clk,
  input logic rst,
  serial_subtractor_if.slave bus
);
  localparam int N_W = cnt_w(C_W);
  state_t state, state_n;
  logic [C_W-1:0] c_sr, b_sr, diff_n;
  logic [C_W-2:0] d_sr;
  logic [N_W-1:0] cnt;
  logic br, d, bout, last;
  fs_cell u_fs (.x(c_sr[0]), .y(b_sr[0]), .bin(br), .d(d), .bout(bout));
  assign last = cnt == N_W'(C_W - 1);
  // the final bit is still combinational when the result is registered
  assign diff_n = {d, d_sr};
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (bus.start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      c_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      cnt <= '0;
      br <= 1'b0;
      bus.diff <= '0;
      bus.a <= '0;
      bus.borrow <= 1'b0;
      bus.ovf <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      c_sr <= bus.c;
      b_sr <= C_W'(bus.b);
      br <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      br <= bout;
      d_sr <= {d, d_sr[C_W-2:1]};
      c_sr <= c_sr >> 1;
      b_sr <= b_sr >> 1;
      cnt <= cnt + 1'b1;
      if (last) begin
        bus.diff <= diff_n;
        bus.a <= diff_n[A_W-1:0];
        bus.borrow <= bout;
        bus.ovf <= !bout && (diff_n >> A_W) != '0;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  serial_subtractor_if bus ();
  serial_subtractor dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // expected {diff, a, borrow, ovf} from plain integer subtraction
  function automatic logic [13:0] model(input logic [7:0] cv, input logic [3:0] bv);
    int dd;
    logic [7:0] df;
    logic bo;
    dd = int'(cv) - int'(bv);
    df = dd[7:0];
    bo = dd < 0;
    return {df, df[3:0], bo, !bo && dd > 15};
  endfunction

  function automatic logic [13:0] obs();
    return {bus.diff, bus.a, bus.borrow, bus.ovf};
  endfunction

  // call #1 after a posedge; returns in the done cycle (or after a timeout with lat = -1)
  task automatic run_op(input logic [7:0] cv, input logic [3:0] bv, input int pulse_at,
                        output int lat, output bit busy_ok);
    bus.start = 1'b1;
    bus.c = cv;
    bus.b = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.c = 8'($urandom);
    bus.b = 4'($urandom);
    busy_ok = bus.busy === 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (k == pulse_at) bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      busy_ok &= bus.busy === 1'b1;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic finish_op(output bit idle_ok);
    @(posedge clk);
    #1;
    idle_ok = bus.busy === 1'b0 && bus.done === 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.busy, bus.done, obs()} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h want=0000", {bus.busy, bus.done, obs()});
    end
    bus.start = 1'b1;
    bus.c = 8'd5;
    bus.b = 4'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    rst = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_beats_start busy=%b want=0", bus.busy);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle busy=%b want=0", bus.busy);
    end
  endtask

  task automatic test_directed();
    logic [7:0] cs [4] = '{8'd2, 8'd0, 8'd200, 8'd30};
    logic [3:0] bs [4] = '{4'd1, 4'd1, 4'd3, 4'd15};
    int lat;
    bit bok, iok;
    for (int i = 0; i < 4; i++) begin
      run_op(cs[i], bs[i], 0, lat, bok);
      n_cmp++;
      if ({lat[7:0], bok, obs()} !== {8'd8, 1'b1, model(cs[i], bs[i])}) begin
        n_bad++;
        $display("FAIL directed%0d got lat=%0d busy=%b res=%h want lat=8 busy=1 res=%h",
                 i, lat, bok, obs(), model(cs[i], bs[i]));
      end
      finish_op(iok);
      n_cmp++;
      if (iok !== 1'b1) begin
        n_bad++;
        $display("FAIL directed%0d_edge9 busy=%b done=%b want 0 0", i, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, extra;
    bit bok, iok;
    logic [13:0] held;
    run_op(8'd30, 4'd15, 3, lat, bok);
    n_cmp++;
    if ({lat[7:0], bok, obs()} !== {8'd8, 1'b1, model(8'd30, 4'd15)}) begin
      n_bad++;
      $display("FAIL ignore_start got lat=%0d res=%h want lat=8 res=%h", lat, obs(), model(8'd30, 4'd15));
    end
    held = obs();
    finish_op(iok);
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) extra++;
    end
    n_cmp++;
    if ({iok, extra, obs()} !== {1'b1, 32'd0, held}) begin
      n_bad++;
      $display("FAIL ignore_start_not_queued idle=%b active_cycles=%0d res=%h want 1 0 %h", iok, extra, obs(), held);
    end
  endtask

  task automatic test_reset_abort();
    int lat, dn;
    bit bok, iok;
    bus.start = 1'b1;
    bus.c = 8'd9;
    bus.b = 4'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.done, obs()} !== 16'h0) begin
      n_bad++;
      $display("FAIL abort_outputs got=%h want=0000", {bus.busy, bus.done, obs()});
    end
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dn++;
    end
    n_cmp++;
    if (dn !== 0) begin
      n_bad++;
      $display("FAIL abort_no_done pulses=%0d want=0", dn);
    end
    run_op(8'd9, 4'd4, 0, lat, bok);
    n_cmp++;
    if ({lat[7:0], bok, obs()} !== {8'd8, 1'b1, model(8'd9, 4'd4)}) begin
      n_bad++;
      $display("FAIL after_abort got lat=%0d res=%h want lat=8 res=%h", lat, obs(), model(8'd9, 4'd4));
    end
    finish_op(iok);
  endtask

  task automatic test_round_trip();
    int lat;
    bit bok, iok;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        run_op(8'(x + y), 4'(y), 0, lat, bok);
        n_cmp++;
        if ({lat[7:0], bus.a, bus.borrow, bus.ovf} !== {8'd8, 4'(x), 2'b00}) begin
          n_bad++;
          $display("FAIL round_trip a=%0d b=%0d got lat=%0d a=%0d borrow=%b ovf=%b",
                   x, y, lat, bus.a, bus.borrow, bus.ovf);
        end
        finish_op(iok);
      end
  endtask

  task automatic test_back_to_back_random();
    int lat;
    bit bok, iok;
    logic [7:0] cv;
    logic [3:0] bv;
    for (int i = 0; i < 150; i++) begin
      cv = 8'($urandom_range(0, 255));
      bv = 4'($urandom);
      if (i % 10 == 0) cv = 8'($urandom_range(0, 15));
      run_op(cv, bv, 0, lat, bok);
      finish_op(iok);
      n_cmp++;
      if ({lat[7:0], bok, iok, obs()} !== {8'd8, 1'b1, 1'b1, model(cv, bv)}) begin
        n_bad++;
        $display("FAIL random c=%0d b=%0d got lat=%0d busy=%b idle=%b res=%h want res=%h",
                 cv, bv, lat, bok, iok, obs(), model(cv, bv));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.c = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_round_trip();
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor that undoes the team's 4-bit adder: it takes an 8-bit sum `c` and one 4-bit addend `b` and recovers the other addend `a = c - b`. It processes one bit per clock, LSB first, under a start/busy/done handshake. It sits downstream of the adder in checking and round-trip datapaths, and reports borrow (when `c < b`) and overflow (when the difference does not fit in 4 bits).

## Interface
Parameters:
- `C_W`, default 8: width of minuend `c` and of the full difference `diff`.
- `B_W`, default 4: width of subtrahend `b`; zero-extended to `C_W` internally.
- `A_W`, default 4: width of the recovered addend `a`. Must satisfy `A_W <= C_W`.

Ports (clock and reset first):
- `clk`, in, 1: single clock; all logic is rising-edge triggered.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request; sampled only in IDLE.
- `c`, in, `C_W`: minuend; captured on the accepting edge.
- `b`, in, `B_W`: subtrahend; captured on the accepting edge.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle pulse; results are valid from this cycle on.
- `diff`, out, `C_W`: `c - b` modulo 2^`C_W`.
- `a`, out, `A_W`: `diff[A_W-1:0]`.
- `borrow`, out, 1: final borrow out of the MSB, i.e. `c < b`.
- `ovf`, out, 1: `!borrow && diff[C_W-1:A_W] != 0`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On `start`: load `c` into shift register `c_sr`, load `{0, b}` into `b_sr`, clear the borrow register `br` and the bit counter `cnt`, then go to RUN.
- RUN, each cycle:
  - Bit difference: `d = c_sr[0] ^ b_sr[0] ^ br`.
  - Next borrow: `br <= (~c_sr[0] & b_sr[0]) | (~c_sr[0] & br) | (b_sr[0] & br)`.
  - Shift `d` into the MSB of `d_sr`; shift `c_sr` and `b_sr` right by one; increment `cnt`.
- On the RUN cycle where `cnt == C_W-1`:
  - Register `diff`, `a`, `borrow` and `ovf` from the final shifted values.
  - Go to DONE.
- DONE: `done = 1` for exactly one cycle, then unconditionally return to IDLE.
- Result outputs change only on completion and hold until the next completion.
- `start` in RUN or DONE is ignored. It is not queued; the caller re-asserts it in IDLE.
- Operand inputs are don't-care except on the accepting edge.

## Timing
- Reset values: state IDLE; `busy`, `done`, `diff`, `a`, `borrow`, `ovf` all 0; internal registers 0.
- Edge numbering:
  - `start` is sampled at edge 0.
  - Bits are processed at edges 1..`C_W`.
  - The result and DONE state take effect at edge `C_W` (8).
- Latency: `done` is high for the cycle between edges 8 and 9, i.e. 8 cycles after acceptance.
- Throughput: one operation per `C_W + 2` cycles (10), since the earliest next acceptance is at edge 9+1.
- `busy` rises at edge 0 and falls at edge 9.
- Reset mid-RUN or mid-DONE:
  - Aborts the operation; `done` never pulses for it.
  - Outputs return to 0.
  - The next `start` after reset proceeds normally.
- `rst` and `start` asserted on the same edge: `rst` wins.
- Wrap-around: when `c < b`, `diff` is the two's-complement wrap, `borrow = 1` and `ovf = 0`.

## Structure
- Package `serial_subtractor_pkg` holds:
  - defaults for `C_W`, `B_W`, `A_W`;
  - the state enum (IDLE, RUN, DONE);
  - `CNT_W = $clog2(C_W)`.
- Sub-module `fs_cell`: combinational one-bit full subtractor with inputs x, y, bin and outputs d, bout. It is instantiated once; the top holds the FSM, shift registers and result registers.

## Test plan
- c=2, b=1, start at edge 0: done at edge 8 with diff=1, a=1, borrow=0, ovf=0; busy high for edges 0..9.
- c=0, b=1: diff=8'hFF, a=4'hF, borrow=1, ovf=0.
- c=200, b=3: diff=197 (8'hC5), a=5, borrow=0, ovf=1.
- c=30, b=15: diff=15, a=4'hF, ovf=0. Then pulse start at edge 3 while busy: ignored, exactly one done, outputs unchanged.
- Start c=9, b=4, then assert rst at edge 4: no done; all outputs 0. Then c=9, b=4 again: done 8 cycles later, diff=5.
- Round trip: for all a, b in 0..15, drive the adder's sum as c: recovered a matches, borrow=0, ovf=0.
